// File: rtl/scr1_pipe_mprf_sb.sv
// scr1_pipe_mprf_sb: multi-port integer register file with write-to-read bypass and busy scoreboard
module scr1_pipe_mprf_sb #(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 32,
  parameter  int NRD    = 2,
  parameter  int NWR    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS),
  localparam int CW     = $clog2(NREGS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_ready,
  input  logic [NWR-1:0]      wr_req,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NWR-1:0]      wr_clr,
  input  logic                rsv_req,
  input  logic [AW-1:0]       rsv_addr,
  output logic                rsv_gnt,
  input  logic                flush,
  output logic [NREGS-1:0]    busy_vec,
  output logic [CW-1:0]       pend_cnt
);

  logic [XLEN-1:0]  mprf [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic [AW-1:0]    ra;

  // x0 is never busy, so a reservation of x0 is always granted and changes nothing
  assign rsv_gnt  = rsv_req && (rsv_addr == '0 || !busy[rsv_addr]);
  assign busy_vec = busy;

  // next busy state: flush, then write-side clears, then a granted reservation (new owner wins)
  always_comb begin
    busy_nxt = flush ? '0 : busy;
    for (int p = 0; p < NWR; p++)
      if (wr_req[p] && wr_clr[p]) busy_nxt[wr_addr[p*AW +: AW]] = 1'b0;
    if (rsv_gnt) busy_nxt[rsv_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int r = 0; r < NREGS; r++) cnt_nxt = cnt_nxt + CW'(busy_nxt[r]);
  end

  // scoreboard state and its registered population count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      pend_cnt <= cnt_nxt;
    end

  // register commit; later (higher-index) ports override earlier ones to the same register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) mprf[r] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++)
        if (wr_req[p] && wr_addr[p*AW +: AW] != '0)
          mprf[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
    end

  // read ports: registered state, optionally overridden by the winning same-cycle write
  always_comb begin
    rd_data  = '0;
    rd_ready = '1;
    ra       = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = rd_addr[i*AW +: AW];
      rd_data[i*XLEN +: XLEN] = mprf[ra];
      rd_ready[i] = !busy[ra];
      if (BYPASS != 0)
        for (int p = 0; p < NWR; p++)
          if (wr_req[p] && wr_addr[p*AW +: AW] == ra) begin
            rd_data[i*XLEN +: XLEN] = wr_data[p*XLEN +: XLEN];
            rd_ready[i] = 1'b1;
          end
      if (ra == '0) begin
        rd_data[i*XLEN +: XLEN] = '0;
        rd_ready[i] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scr1_pipe_mprf_sb.sv
// tb_scr1_pipe_mprf_sb: directed bench with a reference model checked every cycle plus literal checks
module tb_scr1_pipe_mprf_sb;

  logic        clk, rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_ready;
  logic [1:0]  wr_req;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [1:0]  wr_clr;
  logic        rsv_req;
  logic [4:0]  rsv_addr;
  logic        rsv_gnt;
  logic        flush;
  logic [31:0] busy_vec;
  logic [5:0]  pend_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  logic [31:0] m_reg [32];
  logic [31:0] m_busy = '0;
  logic [31:0] m_busy_n;

  scr1_pipe_mprf_sb dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
    .rsv_req(rsv_req), .rsv_addr(rsv_addr), .rsv_gnt(rsv_gnt),
    .flush(flush), .busy_vec(busy_vec), .pend_cnt(pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial for (int r = 0; r < 32; r++) m_reg[r] = '0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic m_gnt();
    return rsv_req && (rsv_addr == 5'd0 || !m_busy[rsv_addr]);
  endfunction

  always_comb begin
    m_busy_n = flush ? 32'd0 : m_busy;
    for (int p = 0; p < 2; p++)
      if (wr_req[p] && wr_clr[p]) m_busy_n[wr_addr[p*5 +: 5]] = 1'b0;
    if (m_gnt() && rsv_addr != 5'd0) m_busy_n[rsv_addr] = 1'b1;
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) m_reg[r] <= '0;
      m_busy <= '0;
    end else begin
      for (int p = 0; p < 2; p++)
        if (wr_req[p] && wr_addr[p*5 +: 5] != 5'd0) m_reg[wr_addr[p*5 +: 5]] <= wr_data[p*32 +: 32];
      m_busy <= m_busy_n;
    end

  always @(negedge clk) if (chk_en) begin
    for (int i = 0; i < 2; i++) begin
      logic [4:0]  a;
      logic [31:0] ed;
      logic        er;
      a  = rd_addr[i*5 +: 5];
      ed = m_reg[a];
      er = !m_busy[a];
      for (int p = 0; p < 2; p++)
        if (wr_req[p] && wr_addr[p*5 +: 5] == a) begin
          ed = wr_data[p*32 +: 32];
          er = 1'b1;
        end
      if (a == 5'd0) begin
        ed = '0;
        er = 1'b1;
      end
      chk($sformatf("model_rd_data%0d", i), 64'(rd_data[i*32 +: 32]), 64'(ed));
      chk($sformatf("model_rd_ready%0d", i), 64'(rd_ready[i]), 64'(er));
    end
    chk("model_rsv_gnt", 64'(rsv_gnt), 64'(m_gnt()));
    chk("model_busy_vec", 64'(busy_vec), 64'(m_busy));
    chk("model_pend_cnt", 64'(pend_cnt), 64'($countones(m_busy)));
  end

  task automatic clr_in();
    rd_addr = '0; wr_req = '0; wr_addr = '0; wr_data = '0; wr_clr = '0;
    rsv_req = 1'b0; rsv_addr = '0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr_in();
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d, input logic c);
    wr_req[p] = 1'b1;
    wr_addr[p*5 +: 5] = a;
    wr_data[p*32 +: 32] = d;
    wr_clr[p] = c;
  endtask

  task automatic rsv(input logic [4:0] a);
    rsv_req = 1'b1;
    rsv_addr = a;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_in();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    rd_addr = {5'd0, 5'd5};
    @(negedge clk);
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_rd_ready", 64'(rd_ready), 64'd3);
    chk("rst_busy_vec", 64'(busy_vec), 64'd0);
    chk("rst_pend_cnt", 64'(pend_cnt), 64'd0);
    tick();
    wr(0, 5'd3, 32'hDEADBEEF, 1'b0);
    tick();
    rd_addr = {5'd0, 5'd3};
    @(negedge clk);
    chk("x3_commit", 64'(rd_data[31:0]), 64'hDEADBEEF);
    tick();
    wr(0, 5'd0, 32'h1234, 1'b0);
    rd_addr = {5'd0, 5'd0};
    @(negedge clk);
    chk("x0_no_bypass", 64'(rd_data[31:0]), 64'd0);
    tick();
    @(negedge clk);
    chk("x0_no_commit", 64'(rd_data[31:0]), 64'd0);
    tick();
    wr(0, 5'd7, 32'h11, 1'b0);
    wr(1, 5'd7, 32'h22, 1'b0);
    rd_addr = {5'd7, 5'd0};
    @(negedge clk);
    chk("x7_bypass_prio", 64'(rd_data[63:32]), 64'h22);
    chk("x7_bypass_ready", 64'(rd_ready[1]), 64'd1);
    tick();
    rd_addr = {5'd7, 5'd0};
    @(negedge clk);
    chk("x7_commit_prio", 64'(rd_data[63:32]), 64'h22);
    tick();
    rsv(5'd9);
    @(negedge clk);
    chk("x9_gnt", 64'(rsv_gnt), 64'd1);
    tick();
    rsv(5'd9);
    rd_addr = {5'd0, 5'd9};
    @(negedge clk);
    chk("x9_busy_vec", 64'(busy_vec), 64'h200);
    chk("x9_pend", 64'(pend_cnt), 64'd1);
    chk("x9_not_ready", 64'(rd_ready[0]), 64'd0);
    chk("x9_waw_gnt", 64'(rsv_gnt), 64'd0);
    tick();
    wr(1, 5'd9, 32'h55, 1'b1);
    rd_addr = {5'd0, 5'd9};
    @(negedge clk);
    chk("x9_clr_ready", 64'(rd_ready[0]), 64'd1);
    chk("x9_clr_data", 64'(rd_data[31:0]), 64'h55);
    tick();
    @(negedge clk);
    chk("x9_cleared", 64'(busy_vec), 64'd0);
    chk("x9_pend0", 64'(pend_cnt), 64'd0);
    tick();
    rsv(5'd4);
    tick();
    wr(0, 5'd4, 32'h44, 1'b1);
    rsv(5'd4);
    @(negedge clk);
    chk("x4_busy_gnt", 64'(rsv_gnt), 64'd0);
    tick();
    wr(0, 5'd4, 32'h45, 1'b1);
    rsv(5'd4);
    @(negedge clk);
    chk("x4_free_gnt", 64'(rsv_gnt), 64'd1);
    tick();
    @(negedge clk);
    chk("x4_rsv_beats_clr", 64'(busy_vec), 64'h10);
    tick();
    wr(0, 5'd4, 32'h0, 1'b1);
    tick();
    rsv(5'd1);
    tick();
    rsv(5'd2);
    tick();
    rsv(5'd3);
    tick();
    @(negedge clk);
    chk("pend3_busy", 64'(busy_vec), 64'hE);
    chk("pend3_cnt", 64'(pend_cnt), 64'd3);
    tick();
    flush = 1'b1;
    rsv(5'd6);
    @(negedge clk);
    chk("flush_gnt", 64'(rsv_gnt), 64'd1);
    tick();
    @(negedge clk);
    chk("flush_busy", 64'(busy_vec), 64'h40);
    chk("flush_pend", 64'(pend_cnt), 64'd1);
    tick();
    wr(0, 5'd12, 32'hABCD, 1'b0);
    rd_addr = {5'd12, 5'd3};
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_busy", 64'(busy_vec), 64'd0);
    chk("async_pend", 64'(pend_cnt), 64'd0);
    chk("async_x3", 64'(rd_data[31:0]), 64'd0);
    chk("async_ready", 64'(rd_ready), 64'd3);
    @(posedge clk);
    #1;
    clr_in();
    rst_n = 1'b1;
    rd_addr = {5'd12, 5'd3};
    @(negedge clk);
    chk("async_write_lost", rd_data, 64'd0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
